// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU response-side signature checker.
package alu_pkg;

  // Checker run state: waiting, absorbing results, or holding a verdict.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } chk_state_t;

  localparam int         ALU_W       = 8;
  localparam int         ALU_OPC_W   = 4;
  localparam int         ALU_NUM_OPS = 16;
  localparam logic [7:0] MISR_POLY   = 8'h1D;

endpackage

// File: rtl/misr8.sv
// Galois-form multiple-input signature register. Each enabled cycle the
// register shifts left, folds the shifted-out MSB back in through POLY and
// XORs in the new data word. The next value is also exported so the owner
// can judge a final signature on the same edge that absorbs the last sample.
module misr8
  import alu_pkg::*;
#(
  parameter int               WIDTH = ALU_W,
  parameter logic [WIDTH-1:0] POLY  = MISR_POLY,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  // Next signature for the current data word, whether or not it is used.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    sig_d    = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = sig_next;
    end
  end

  // Signature register; seed load has priority over accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/alu_signature_checker.sv
// Compacts a run of ALU results into a MISR signature, checks that the
// producing opcodes arrive as 1, 2, ..., 15, 0, and reports pass/fail
// against a golden signature once the run completes.
module alu_signature_checker
  import alu_pkg::*;
#(
  parameter int               WIDTH   = ALU_W,
  parameter int               NUM_OPS = ALU_NUM_OPS,
  parameter logic [WIDTH-1:0] SEED    = '0,
  parameter logic [WIDTH-1:0] POLY    = MISR_POLY,
  parameter logic [WIDTH-1:0] GOLDEN  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 res_valid,
  input  logic [WIDTH-1:0]     res,
  input  logic [ALU_OPC_W-1:0] res_opcode,
  output logic [WIDTH-1:0]     signature,
  output logic [4:0]           count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 seq_err
);

  localparam logic [4:0] LAST_COUNT = 5'(NUM_OPS);

  chk_state_t           state_q, state_d;
  logic [4:0]           count_q, count_d;
  logic [ALU_OPC_W-1:0] exp_op_q, exp_op_d;
  logic                 seq_err_q, seq_err_d;
  logic                 pass_q, pass_d;
  logic                 misr_load, misr_en;
  logic [WIDTH-1:0]     sig_next;

  misr8 #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .en       (misr_en),
    .data     (res),
    .sig      (signature),
    .sig_next (sig_next)
  );

  // Next-state logic: start always (re)initialises a run and discards any
  // coincident sample; samples are only absorbed in COLLECT.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    exp_op_d  = exp_op_q;
    seq_err_d = seq_err_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    if (start) begin
      state_d   = COLLECT;
      count_d   = '0;
      exp_op_d  = ALU_OPC_W'(1);
      seq_err_d = 1'b0;
      pass_d    = 1'b0;
      misr_load = 1'b1;
    end else if (state_q == COLLECT && res_valid) begin
      misr_en   = 1'b1;
      count_d   = count_q + 5'd1;
      seq_err_d = seq_err_q | (res_opcode != exp_op_q);
      exp_op_d  = exp_op_q + ALU_OPC_W'(1);
      if (count_d == LAST_COUNT) begin
        state_d = DONE;
        pass_d  = (sig_next == GOLDEN) && !seq_err_d;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      exp_op_q  <= ALU_OPC_W'(1);
      seq_err_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      exp_op_q  <= exp_op_d;
      seq_err_q <= seq_err_d;
      pass_q    <= pass_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == COLLECT);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_alu_signature_checker.sv
// Scoreboard bench: the stimulus process drives one cycle at a time and
// pushes the expected post-edge outputs from a run-level reference model;
// a monitor pops and compares one entry after every rising edge.
module tb_alu_signature_checker;

  localparam logic [7:0] GOLDEN = 8'h26;
  localparam logic [7:0] SEED   = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       res_valid = 1'b0;
  logic [7:0] res = '0;
  logic [3:0] res_opcode = '0;
  logic [7:0] signature;
  logic [4:0] count;
  logic       busy, done, pass, seq_err;

  alu_signature_checker #(
    .WIDTH   (8),
    .NUM_OPS (16),
    .SEED    (SEED),
    .POLY    (8'h1D),
    .GOLDEN  (GOLDEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .res_valid  (res_valid),
    .res        (res),
    .res_opcode (res_opcode),
    .signature  (signature),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sig;
    logic [4:0] cnt;
    logic       busy;
    logic       done;
    logic       pass;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a run is the list of accepted samples.
  bit         running  = 0;
  bit         finished = 0;
  bit         m_pass   = 0;
  logic [7:0] samp[$];
  logic [3:0] opcs[$];

  function automatic logic [7:0] model_sig();
    int s = SEED;
    foreach (samp[i]) begin
      s = (s * 2) % 256;
      if (s != ((s / 2) * 2)) s = s; // keep s integral (no-op)
      s = s ^ samp[i];
    end
    return 8'(s);
  endfunction

  // Polynomial fold written separately from the plain shift so the MSB is
  // examined before it is lost.
  function automatic logic [7:0] model_sig_full();
    int s = SEED;
    foreach (samp[i]) begin
      int hi = (s >= 128);
      s = (s * 2) % 256;
      if (hi != 0) s = s ^ 8'h1D;
      s = s ^ samp[i];
    end
    return 8'(s);
  endfunction

  function automatic bit model_err();
    foreach (opcs[i]) if (opcs[i] != 4'((i + 1) % 16)) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the expected state after the next edge is queued.
  task automatic step(input bit s, input bit v, input logic [7:0] r, input logic [3:0] o);
    exp_t e;
    @(negedge clk);
    start = s; res_valid = v; res = r; res_opcode = o;
    if (s) begin
      running = 1; finished = 0; m_pass = 0;
      samp.delete(); opcs.delete();
    end else if (running && v) begin
      samp.push_back(r); opcs.push_back(o);
      if (samp.size() == 16) begin
        running = 0; finished = 1;
        m_pass = (model_sig_full() == GOLDEN) && !model_err();
      end
    end
    e.sig = model_sig_full(); e.cnt = 5'(samp.size());
    e.busy = running; e.done = finished; e.pass = m_pass; e.err = model_err();
    exp_q.push_back(e);
    $display("txn t=%0t start=%0b valid=%0b res=%02h opc=%0d -> exp sig=%02h cnt=%0d done=%0b",
             $time, s, v, r, o, e.sig, e.cnt, e.done);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("signature", 32'(signature), 32'(e.sig));
        chk("count",     32'(count),     32'(e.cnt));
        chk("busy",      32'(busy),      32'(e.busy));
        chk("done",      32'(done),      32'(e.done));
        chk("pass",      32'(pass),      32'(e.pass));
        chk("seq_err",   32'(seq_err),   32'(e.err));
      end
    end
  end

  task automatic model_reset();
    running = 0; finished = 0; m_pass = 0;
    samp.delete(); opcs.delete();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Full correct-order run: first sample `first`, the rest `rest`.
  task automatic run_fixed(input logic [7:0] first, input logic [7:0] rest, input int bad_idx);
    step(1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] o = 4'((i + 1) % 16);
      if (i == bad_idx) o = 4'd7;
      step(0, 1, (i == 0) ? first : rest, o);
    end
    step(0, 0, 8'h00, 4'd0);
  endtask

  initial begin
    // Reset state, checked directly while rst is held.
    #3;
    chk("rst_signature", 32'(signature), 32'(SEED));
    chk("rst_count", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    @(negedge clk);
    rst = 0;

    // Samples in IDLE are ignored.
    step(0, 1, 8'h5A, 4'd1);
    step(0, 1, 8'h33, 4'd2);

    // Zero stream.
    run_fixed(8'h00, 8'h00, -1);
    settle();
    chk("zero_sig", 32'(signature), 32'h00);
    chk("zero_done", 32'(done), 1);

    // Impulse stream reaches the golden signature.
    run_fixed(8'h01, 8'h00, -1);
    settle();
    chk("impulse_sig", 32'(signature), 32'h26);
    chk("impulse_pass", 32'(pass), 1);

    // Ignored pulses in DONE, then start coincident with a valid sample.
    step(0, 1, 8'hFF, 4'd1);
    step(0, 1, 8'h12, 4'd2);
    settle();
    chk("done_hold_sig", 32'(signature), 32'h26);
    chk("done_hold_cnt", 32'(count), 16);
    step(1, 1, 8'hAB, 4'd1);
    settle();
    chk("start_discard_cnt", 32'(count), 0);

    // Opcode order error on the 4th sample.
    run_fixed(8'h01, 8'h00, 3);
    settle();
    chk("seqerr_flag", 32'(seq_err), 1);
    chk("seqerr_pass", 32'(pass), 0);

    // Gapped valid with a restart after 9 samples, then a full gapped run.
    step(1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 18; i++) step(0, (i % 2) == 1, 8'($urandom), 4'((i / 2 + 1) % 16));
    step(1, 1, 8'h77, 4'd10);
    settle();
    chk("restart_cnt", 32'(count), 0);
    chk("restart_sig", 32'(signature), 32'(SEED));
    for (int i = 0; i < 32; i++) step(0, (i % 2) == 0, 8'($urandom), 4'((i / 2 + 1) % 16));
    step(0, 0, 8'h00, 4'd0);

    // Asynchronous reset mid-run after 5 samples.
    step(1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom_range(1, 255)), 4'(i + 1));
    settle();
    @(negedge clk);
    #1;
    rst = 1;
    model_reset();
    #1;
    chk("midrst_sig", 32'(signature), 32'(SEED));
    chk("midrst_cnt", 32'(count), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk);
    rst = 0;

    // Randomised runs with gaps, occasional wrong opcodes and restarts.
    for (int run = 0; run < 6; run++) begin
      int guard = 0;
      step(1, 0, 8'h00, 4'd0);
      while (!finished && guard < 100) begin
        bit v = ($urandom_range(0, 3) != 0);
        logic [3:0] o = 4'((samp.size() + 1) % 16);
        if ($urandom_range(0, 15) == 0) o = 4'($urandom);
        step(($urandom_range(0, 59) == 0), v, 8'($urandom), o);
        guard++;
      end
      step(0, 1, 8'($urandom), 4'($urandom));
    end

    // Drain the scoreboard within a bounded number of cycles.
    begin
      int wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
        @(posedge clk);
        wait_cycles++;
      end
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
